vector_write_sequencer: RTL and testbench

Streaming front end for the dot-product memory subsystem. Accepts element pairs (a[i], b[i]) from an upstream valid/ready source and buffers them in a FIFO. Once a full vector is buffered, it drives the write side of `mem_controller` (`start` / `in_valid` / `data_a` / `data_b`, waiting on `busy` and `done`). This replaces bench-driven memory loading, so vectors are written without software pacing.

---
 rtl/vector_write_sequencer_if.sv | 29 ++
 rtl/vector_write_sequencer.sv | 130 +++++++++++++
 tb/tb_vector_write_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_write_sequencer_if.sv
// Bundles the upstream pair stream and the mem_controller write port of vector_write_sequencer.
// Upstream handshake: a pair transfers on a rising clk edge where s_valid && s_ready are both high;
// s_data_a/b must be stable while s_valid is high, and s_ready depends only on FIFO occupancy and rst.
interface vector_write_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data_a;
  logic [DATA_WIDTH-1:0] s_data_b;
  logic                  mem_start;
  logic                  mem_in_valid;
  logic [DATA_WIDTH-1:0] mem_data_a;
  logic [DATA_WIDTH-1:0] mem_data_b;
  logic                  mem_busy;
  logic                  mem_done;

  // master: the sequencer (consumes the pair stream, drives the memory write port)
  modport master (
    input  s_valid, s_data_a, s_data_b, mem_busy, mem_done,
    output s_ready, mem_start, mem_in_valid, mem_data_a, mem_data_b
  );

  // slave: the environment (pair source plus mem_controller)
  modport slave (
    output s_valid, s_data_a, s_data_b, mem_busy, mem_done,
    input  s_ready, mem_start, mem_in_valid, mem_data_a, mem_data_b
  );
endinterface

// File: rtl/vector_write_sequencer.sv
// Buffers (a,b) element pairs in a FIFO and, once a whole vector is held, writes it to
// mem_controller as START, then alternating SEND/GAP cycles, then waits for mem_done.
module vector_write_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  vector_write_sequencer_if.master      bus,
  output logic                          frame_done,
  output logic                          timeout_err,
  output logic [15:0]                   frames_sent,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] VEC_L     = LW'(VECTOR_WIDTH);
  localparam logic [EW-1:0] LAST_ELEM = EW'(VECTOR_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SEND      = 3'd2,
    GAP       = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [EW-1:0]           elem_cnt_q;
  logic [TW-1:0]           to_cnt_q;
  logic [DATA_WIDTH-1:0]   data_a_q, data_b_q;
  logic                    frame_done_q, timeout_err_q;
  logic [15:0]             frames_sent_q;
  logic                    s_ready_w, push, pop, done_evt, to_evt;

  assign s_ready_w = !rst && (level_q < DEPTH_L);
  assign push      = bus.s_valid && s_ready_w;
  assign pop       = (state_q == SEND);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_evt = 1'b0;
    to_evt   = 1'b0;
    case (state_q)
      // A whole frame is already buffered here, so SEND never has to stall for data.
      IDLE:      if (level_q >= VEC_L && !bus.mem_busy) state_d = START;
      START:     state_d = SEND;
      SEND:      state_d = (elem_cnt_q == LAST_ELEM) ? WAIT_DONE : GAP;
      GAP:       state_d = SEND;
      WAIT_DONE: begin
        if (bus.mem_done) begin
          done_evt = 1'b1;
          state_d  = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          to_evt  = 1'b1;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {bus.s_data_a, bus.s_data_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      elem_cnt_q    <= '0;
      to_cnt_q      <= '0;
      data_a_q      <= '0;
      data_b_q      <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (state_q == START) elem_cnt_q <= '0;
      else if (pop)         elem_cnt_q <= elem_cnt_q + 1'b1;
      to_cnt_q <= (state_q == WAIT_DONE) ? to_cnt_q + 1'b1 : '0;
      // Load the head one cycle early so the data registers are valid throughout SEND.
      if (state_d == SEND) begin
        {data_a_q, data_b_q} <= fifo_mem_q[rd_ptr_q];
      end
      frame_done_q  <= done_evt;
      timeout_err_q <= to_evt;
      if (done_evt) frames_sent_q <= frames_sent_q + 16'd1;
    end
  end

  assign bus.s_ready      = s_ready_w;
  assign bus.mem_start    = (state_q == START) || (state_q == SEND) || (state_q == GAP);
  assign bus.mem_in_valid = (state_q == SEND);
  assign bus.mem_data_a   = data_a_q;
  assign bus.mem_data_b   = data_b_q;
  assign frame_done       = frame_done_q;
  assign timeout_err      = timeout_err_q;
  assign frames_sent      = frames_sent_q;
  assign fifo_level       = level_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_vector_write_sequencer.sv
// Directed bench for vector_write_sequencer: a frame table plus hand-written sequences for
// backpressure, simultaneous push/pop, stray done and reset in the middle of a frame.
module tb_vector_write_sequencer;

  logic        clk;
  logic        rst;
  logic        frame_done;
  logic        timeout_err;
  logic [15:0] frames_sent;
  logic [3:0]  fifo_level;
  logic [2:0]  dbg_state;

  vector_write_sequencer_if #(.DATA_WIDTH(8)) vif();

  vector_write_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (vif),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frames_sent (frames_sent),
    .fifo_level  (fifo_level),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before 400us");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_fs = 0;
  int          run_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (vif.mem_in_valid) begin
      if (exp_q.size() == 0) check("unexpected_write", {vif.mem_data_a, vif.mem_data_b}, -1);
      else check("write_data", {vif.mem_data_a, vif.mem_data_b}, exp_q.pop_front());
    end
    if (rst) run_len = 0;
    else if (vif.mem_start) run_len++;
    else if (run_len != 0) begin
      check("start_len", run_len, 8);
      run_len = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    vif.s_valid  = 1'b1;
    vif.s_data_a = a;
    vif.s_data_b = b;
    while (!vif.s_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!vif.s_ready) check("push_accept", 0, 1);
    else begin
      exp_q.push_back({a, b});
      tick(1);
    end
    vif.s_valid = 1'b0;
  endtask

  task automatic wait_start(input logic level);
    int n = 0;
    while (vif.mem_start != level && n < 60) begin
      tick(1);
      n++;
    end
    check(level ? "start_rise" : "start_fall", vif.mem_start, level);
  endtask

  // Runs from the frame's START (or earlier) through WAIT_DONE resolution.
  task automatic finish_frame(input int delay, input bit expect_to, input int exp_level);
    wait_start(1'b1);
    wait_start(1'b0);
    check("level_in_wait", fifo_level, exp_level);
    if (expect_to) begin
      tick(63);
      check("timeout_early", timeout_err, 0);
      tick(1);
      check("timeout_pulse", timeout_err, 1);
      check("timeout_no_count", frames_sent, exp_fs);
      tick(1);
      check("timeout_clear", timeout_err, 0);
      check("timeout_idle", vif.mem_start, 0);
    end else begin
      tick(delay);
      vif.mem_done = 1'b1;
      tick(1);
      vif.mem_done = 1'b0;
      exp_fs++;
      check("frame_done_pulse", frame_done, 1);
      check("frames_sent", frames_sent, exp_fs);
      tick(1);
      check("frame_done_clear", frame_done, 0);
    end
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    logic [7:0] a [4];
    logic [7:0] b [4];
    int         done_delay;
    bit         exp_timeout;
    int         exp_frames;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0].a = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[0].b = '{8'd1, 8'd1, 8'd1, 8'd1};
    tbl[0].done_delay = 3; tbl[0].exp_timeout = 1'b0; tbl[0].exp_frames = 1;
    tbl[1].a = '{8'd2, 8'd4, 8'd6, 8'd8};
    tbl[1].b = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[1].done_delay = 0; tbl[1].exp_timeout = 1'b0; tbl[1].exp_frames = 2;
    tbl[2].a = '{8'd0, 8'd5, 8'd0, 8'd3};
    tbl[2].b = '{8'd2, 8'd0, 8'd4, 8'd1};
    tbl[2].done_delay = 1; tbl[2].exp_timeout = 1'b0; tbl[2].exp_frames = 3;
    tbl[3].a = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[3].b = '{8'd1, 8'd1, 8'd1, 8'd1};
    tbl[3].done_delay = 0; tbl[3].exp_timeout = 1'b1; tbl[3].exp_frames = 3;

    rst = 1'b1;
    vif.s_valid = 1'b0; vif.s_data_a = '0; vif.s_data_b = '0;
    vif.mem_busy = 1'b0; vif.mem_done = 1'b0;
    tick(3);
    check("rst_s_ready_low", vif.s_ready, 0);
    rst = 1'b0;
    tick(1);
    check("rst_s_ready", vif.s_ready, 1);
    check("rst_mem_start", vif.mem_start, 0);
    check("rst_in_valid", vif.mem_in_valid, 0);
    check("rst_data", {vif.mem_data_a, vif.mem_data_b}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_level", fifo_level, 0);

    // stray mem_done in IDLE
    vif.mem_done = 1'b1;
    tick(1);
    vif.mem_done = 1'b0;
    check("stray_done_pulse", frame_done, 0);
    tick(1);
    check("stray_done_count", frames_sent, 0);
    check("stray_done_start", vif.mem_start, 0);

    // table: single frame, back-to-back pair, timeout
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) push_pair(tbl[i].a[k], tbl[i].b[k]);
      finish_frame(tbl[i].done_delay, tbl[i].exp_timeout, 0);
      check("tbl_frames_sent", frames_sent, tbl[i].exp_frames);
      check("tbl_level_end", fifo_level, 0);
      check("tbl_sb_empty", exp_q.size(), 0);
    end

    // backpressure: busy holds the sequencer in IDLE while the FIFO fills
    vif.mem_busy = 1'b1;
    for (int k = 0; k < 8; k++) push_pair(8'(8'h10 + k), 8'(8'h20 + k));
    check("bp_ready_low", vif.s_ready, 0);
    check("bp_level_full", fifo_level, 8);
    vif.s_valid = 1'b1; vif.s_data_a = 8'h99; vif.s_data_b = 8'h99;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("bp_no_accept", fifo_level, 8);
      check("bp_no_start", vif.mem_start, 0);
    end
    vif.s_valid = 1'b0;
    vif.mem_busy = 1'b0;
    finish_frame(2, 1'b0, 4);
    finish_frame(1, 1'b0, 0);
    check("bp_sb_empty", exp_q.size(), 0);

    // push during SEND keeps the level constant
    for (int k = 0; k < 4; k++) push_pair(8'(8'h30 + k), 8'(8'h40 + k));
    wait_start(1'b1);
    tick(1);
    check("pp_send", vif.mem_in_valid, 1);
    check("pp_level_before", fifo_level, 4);
    vif.s_valid = 1'b1; vif.s_data_a = 8'h11; vif.s_data_b = 8'h22;
    exp_q.push_back(16'h1122);
    tick(1);
    vif.s_valid = 1'b0;
    check("pp_level_same", fifo_level, 4);
    finish_frame(2, 1'b0, 1);

    // reset after the second in_valid of a frame
    for (int k = 0; k < 3; k++) push_pair(8'(8'h50 + k), 8'(8'h60 + k));
    wait_start(1'b1);
    tick(3);
    check("rm_second_send", vif.mem_in_valid, 1);
    rst = 1'b1;
    tick(1);
    check("rm_start", vif.mem_start, 0);
    check("rm_in_valid", vif.mem_in_valid, 0);
    check("rm_level", fifo_level, 0);
    check("rm_data", {vif.mem_data_a, vif.mem_data_b}, 0);
    check("rm_frames_sent", frames_sent, 0);
    check("rm_ready_low", vif.s_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_fs = 0;
    tick(2);
    check("rm_idle", vif.mem_start, 0);
    check("rm_ready", vif.s_ready, 1);

    for (int k = 0; k < 4; k++) push_pair(tbl[0].a[k], tbl[0].b[k]);
    finish_frame(3, 1'b0, 0);
    check("post_rst_frames", frames_sent, 1);
    check("post_rst_sb_empty", exp_q.size(), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
